// File: rtl/hbridge_pulse_monitor.sv
`default_nettype none
// ==== hbridge_pulse_monitor: H-bridge pulse width/period monitor with fault flags; HBRIDGE_MON_SYNC_EN adds a 2-flop input sync. Rev 1.0 ====
module hbridge_pulse_monitor #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   H1,
  input  logic                   H2,
  input  logic                   enable,
  input  logic [CNT_WIDTH-1:0]   cfg_timeout,
  input  logic                   status_clear,
  output logic [3*CNT_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [3:0]             status
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POS  = 3'd1,
    GAP1 = 3'd2,
    NEG  = 3'd3,
    GAP2 = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == C_MAX) ? v : v + C_ONE;
  endfunction

  logic w_s1;
  logic w_s2;

`ifdef HBRIDGE_MON_SYNC_EN
  logic [1:0] r_h1_sync;
  logic [1:0] r_h2_sync;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_h1_sync <= 2'b00;
      r_h2_sync <= 2'b00;
    end else begin
      r_h1_sync <= {r_h1_sync[0], H1};
      r_h2_sync <= {r_h2_sync[0], H2};
    end
  end

  assign w_s1 = r_h1_sync[1];
  assign w_s2 = r_h2_sync[1];
`else
  logic r_h1_smp;
  logic r_h2_smp;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_h1_smp <= 1'b0;
      r_h2_smp <= 1'b0;
    end else begin
      r_h1_smp <= H1;
      r_h2_smp <= H2;
    end
  end

  assign w_s1 = r_h1_smp;
  assign w_s2 = r_h2_smp;
`endif

  logic r_s1_d;
  logic r_s2_d;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_s1_d <= 1'b0;
      r_s2_d <= 1'b0;
    end else begin
      r_s1_d <= w_s1;
      r_s2_d <= w_s2;
    end
  end

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_pos;
  logic [CNT_WIDTH-1:0] r_neg;
  logic [CNT_WIDTH-1:0] r_period;

  logic w_h1_rise;
  logic w_h2_rise;
  logic w_active;
  logic w_shoot;
  logic w_timeout;
  logic w_seq_err;
  logic w_emit;
  logic w_overrun;

  assign w_h1_rise = w_s1 & ~r_s1_d;
  assign w_h2_rise = w_s2 & ~r_s2_d;
  assign w_active  = (r_state != IDLE);
  // Fault priority: shoot-through, then timeout, then sequence error / normal flow.
  assign w_shoot   = enable & w_s1 & w_s2;
  assign w_timeout = enable & ~w_shoot & w_active & (cfg_timeout != '0) & (r_period >= cfg_timeout);
  assign w_seq_err = enable & ~w_shoot & ~w_timeout & (r_state == GAP2) & w_h1_rise;
  assign w_emit    = enable & ~w_shoot & ~w_timeout & w_active & w_h2_rise;
  assign w_overrun = w_emit & m_axis_tvalid & ~m_axis_tready;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state  <= IDLE;
      r_pos    <= '0;
      r_neg    <= '0;
      r_period <= '0;
    end else if (!enable || w_shoot || w_timeout || w_seq_err) begin
      r_state  <= IDLE;
      r_pos    <= '0;
      r_neg    <= '0;
      r_period <= '0;
    end else if (w_h2_rise && (w_emit || r_state == IDLE)) begin
      // A rising H2 both closes the previous period and opens the next one.
      r_state  <= POS;
      r_pos    <= C_ONE;
      r_neg    <= '0;
      r_period <= C_ONE;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        POS: begin
          r_period <= sat_inc(r_period);
          if (w_s2) begin
            r_pos <= sat_inc(r_pos);
          end else if (w_s1) begin
            r_state <= NEG;
            r_neg   <= sat_inc(r_neg);
          end else begin
            r_state <= GAP1;
          end
        end
        GAP1: begin
          r_period <= sat_inc(r_period);
          if (w_h1_rise) begin
            r_state <= NEG;
            r_neg   <= sat_inc(r_neg);
          end
        end
        NEG: begin
          r_period <= sat_inc(r_period);
          if (w_s1) begin
            r_neg <= sat_inc(r_neg);
          end else begin
            r_state <= GAP2;
          end
        end
        GAP2: begin
          r_period <= sat_inc(r_period);
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      status        <= 4'b0000;
    end else begin
      if (w_emit && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata  <= {r_period, r_neg, r_pos};
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      // A new fault in the clearing cycle survives the clear.
      status <= (status & ~{4{status_clear}}) | {w_overrun, w_timeout, w_seq_err, w_shoot};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hbridge_pulse_monitor.sv
`default_nettype none
// tb_hbridge_pulse_monitor: directed H-bridge pulse trains checked against a timestamp/count model.
module tb_hbridge_pulse_monitor;
  localparam int W = 16;
`ifdef HBRIDGE_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [3*W-1:0] R_NOM = {16'd100, 16'd20, 16'd20};
  localparam logic [3*W-1:0] R_90  = {16'd90, 16'd20, 16'd20};
  localparam logic [3*W-1:0] R_ZN  = {16'd64, 16'd0, 16'd10};

  logic           clk = 1'b0;
  logic           areset;
  logic           H1;
  logic           H2;
  logic           enable;
  logic [W-1:0]   cfg_timeout;
  logic           status_clear;
  logic [3*W-1:0] m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [3:0]     status;

  always #5 clk = ~clk;

  hbridge_pulse_monitor #(.CNT_WIDTH(W)) dut (
    .clk(clk), .areset(areset), .H1(H1), .H2(H2), .enable(enable),
    .cfg_timeout(cfg_timeout), .status_clear(status_clear),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .status(status)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a period is the time between accepted H2 rises; widths are counts of high samples.
  logic           m_p1 [0:LAT-1];
  logic           m_p2 [0:LAT-1];
  logic           m_s1d, m_s2d;
  bit             m_active;
  longint         m_now = 0;
  longint         m_start, m_posc, m_negc;
  int             m_h1cnt;
  logic           m_tv;
  logic [3*W-1:0] m_td;
  logic [3:0]     m_st;
  logic [3*W-1:0] rec_q [$];
  longint         rec_t [$];

  function automatic logic [W-1:0] sat(input longint v);
    longint maxv;
    maxv = (longint'(1) << W) - 1;
    if (v > maxv) return '1;
    return v[W-1:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LAT; i++) begin
      m_p1[i] = 1'b0;
      m_p2[i] = 1'b0;
    end
    m_s1d = 1'b0; m_s2d = 1'b0;
    m_active = 1'b0;
    m_tv = 1'b0; m_td = '0; m_st = 4'b0000;
  endtask

  task automatic model_step();
    logic s1, s2, h1r, h2r, emit;
    logic [3:0] set;
    logic [3*W-1:0] rec;
    longint elapsed;
    s1 = m_p1[LAT-1]; s2 = m_p2[LAT-1];
    h1r = s1 & ~m_s1d; h2r = s2 & ~m_s2d;
    elapsed = m_now - m_start;
    set = 4'b0000; emit = 1'b0; rec = '0;
    if (!enable) m_active = 1'b0;
    else if (s1 && s2) begin set[0] = 1'b1; m_active = 1'b0; end
    else if (m_active && cfg_timeout != 0 && elapsed >= longint'(cfg_timeout)) begin
      set[2] = 1'b1; m_active = 1'b0;
    end else if (m_active && h2r) begin
      emit = 1'b1;
      rec = {sat(elapsed), sat(m_negc), sat(m_posc)};
      m_start = m_now; m_posc = 1; m_negc = 0; m_h1cnt = 0;
    end else if (m_active && h1r && m_h1cnt >= 1) begin
      set[1] = 1'b1; m_active = 1'b0;
    end else if (m_active) begin
      m_posc += longint'(s2); m_negc += longint'(s1); m_h1cnt += int'(h1r);
    end else if (h2r) begin
      m_active = 1'b1; m_start = m_now; m_posc = 1; m_negc = 0; m_h1cnt = 0;
    end
    if (emit) begin
      if (!m_tv || m_axis_tready) begin m_td = rec; m_tv = 1'b1; end
      else set[3] = 1'b1;
    end else if (m_tv && m_axis_tready) m_tv = 1'b0;
    m_st = (m_st & ~{4{status_clear}}) | set;
    m_s1d = s1; m_s2d = s2;
    for (int i = LAT - 1; i > 0; i--) begin
      m_p1[i] = m_p1[i-1];
      m_p2[i] = m_p2[i-1];
    end
    m_p1[0] = H1; m_p2[0] = H2;
    m_now++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (areset) model_reset();
      check("tvalid", m_axis_tvalid, m_tv);
      if (m_tv) check("tdata", m_axis_tdata, m_td);
      check("status", status, m_st);
      if (m_axis_tvalid && m_axis_tready) begin
        rec_q.push_back(m_axis_tdata);
        rec_t.push_back(m_now);
      end
      if (!areset) model_step();
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic h1, input logic h2, input int n);
    H1 = h1; H2 = h2;
    tick(n);
  endtask

  task automatic hb_period(input int pw, input int g1, input int nw, input int g2);
    drive(1'b0, 1'b1, pw);
    drive(1'b0, 1'b0, g1);
    drive(1'b1, 1'b0, nw);
    drive(1'b0, 1'b0, g2);
  endtask

  task automatic restart();
    enable = 1'b0;
    drive(1'b0, 1'b0, 4);
    enable = 1'b1;
    drive(1'b0, 1'b0, 4);
  endtask

  task automatic clear_status();
    status_clear = 1'b1;
    tick(1);
    status_clear = 1'b0;
  endtask

  initial begin
    int base;
    areset = 1'b1; H1 = 1'b0; H2 = 1'b0; enable = 1'b1; cfg_timeout = '0;
    status_clear = 1'b0; m_axis_tready = 1'b1;
    tick(3);
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tdata", m_axis_tdata, 0);
    check("reset_status", status, 0);
    areset = 1'b0;
    tick(2);

    // Nominal 100-cycle train
    base = rec_q.size();
    repeat (5) hb_period(20, 30, 20, 30);
    check("nom_count", rec_q.size() - base, 4);
    check("nom_rec_first", rec_q[base], R_NOM);
    check("nom_rec_last", rec_q[base+3], R_NOM);
    check("nom_spacing", rec_t[base+1] - rec_t[base], 100);
    check("nom_status", status, 0);

    // H2-only train
    restart();
    base = rec_q.size();
    repeat (4) begin
      drive(1'b0, 1'b1, 10);
      drive(1'b0, 1'b0, 54);
    end
    check("zneg_count", rec_q.size() - base, 3);
    check("zneg_rec", rec_q[base], R_ZN);
    check("zneg_rec_last", rec_q[base+2], R_ZN);

    // Shoot-through mid-NEG
    restart();
    base = rec_q.size();
    hb_period(20, 30, 20, 30);
    drive(1'b0, 1'b1, 20); drive(1'b0, 1'b0, 30);
    drive(1'b1, 1'b0, 10); drive(1'b1, 1'b1, 1); drive(1'b1, 1'b0, 9);
    drive(1'b0, 1'b0, 30);
    check("shoot_status", status, 4'b0001);
    check("shoot_count_after_glitch", rec_q.size() - base, 1);
    repeat (3) hb_period(20, 30, 20, 30);
    check("shoot_count_resync", rec_q.size() - base, 3);
    check("shoot_rec_resync", rec_q[base+1], R_NOM);
    clear_status();

    // Timeout and clear
    restart();
    base = rec_q.size();
    cfg_timeout = 16'd50;
    drive(1'b0, 1'b1, 10);
    drive(1'b0, 1'b0, LAT + 40);
    check("timeout_before", status, 4'b0000);
    tick(1);
    check("timeout_set", status, 4'b0100);
    drive(1'b0, 1'b0, 30);
    check("timeout_no_record", rec_q.size() - base, 0);
    clear_status();
    check("timeout_cleared", status, 4'b0000);
    cfg_timeout = '0;

    // Backpressure over three periods
    restart();
    base = rec_q.size();
    m_axis_tready = 1'b0;
    hb_period(20, 30, 20, 30);
    repeat (3) hb_period(20, 30, 20, 20);
    drive(1'b0, 1'b1, 20); drive(1'b0, 1'b0, 30); drive(1'b1, 1'b0, 20); drive(1'b0, 1'b0, 5);
    check("bp_tvalid_held", m_axis_tvalid, 1);
    check("bp_tdata_held", m_axis_tdata, R_NOM);
    check("bp_overrun", status, 4'b1000);
    check("bp_no_transfer", rec_q.size() - base, 0);
    m_axis_tready = 1'b1;
    tick(1);
    check("bp_one_transfer", rec_q.size() - base, 1);
    check("bp_transferred", rec_q[base], R_NOM);
    drive(1'b0, 1'b0, 14);
    check("bp_tvalid_drop", m_axis_tvalid, 0);
    repeat (2) hb_period(20, 30, 20, 20);
    check("bp_count_after", rec_q.size() - base, 3);
    check("bp_next_rec", rec_q[base+1], R_90);

    // Reset during NEG with a record pending
    m_axis_tready = 1'b0;
    hb_period(20, 30, 20, 30);
    drive(1'b0, 1'b1, 20); drive(1'b0, 1'b0, 30); drive(1'b1, 1'b0, 10);
    check("pre_reset_tvalid", m_axis_tvalid, 1);
    areset = 1'b1;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_status", status, 0);
    check("rst_tdata", m_axis_tdata, 0);
    drive(1'b1, 1'b0, 3);
    areset = 1'b0;
    m_axis_tready = 1'b1;
    base = rec_q.size();
    drive(1'b1, 1'b0, 7); drive(1'b0, 1'b0, 30);
    hb_period(20, 30, 20, 30);
    check("rst_first_rise_no_rec", rec_q.size() - base, 0);
    repeat (2) hb_period(20, 30, 20, 30);
    check("rst_count", rec_q.size() - base, 2);
    check("rst_first_rec", rec_q[base], R_NOM);
    drive(1'b0, 1'b0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
